// File: rtl/spi_shift_xcvr_if.sv
// ---------------------------------------------------------------------------
// spi_shift_xcvr_if
// Signal bundle between the SPI controller (master side: controller FSM plus
// clock generator strobes, serial input) and the full-duplex shift engine
// (slave side).
//
// Parameters : WIDTH  frame length in bits
//              CNT_W  bit-counter width (2**CNT_W >= WIDTH)
// Signals    : load, tx_data, lsb_first, sample_stb, shift_stb, miso   -> engine
//              mosi, rx_data, busy, done, bit_cnt                    <- engine
// Optional   : SPI_XCVR_OVERRUN_EN adds rx_ack (-> engine) and
//              rx_valid, overrun (<- engine).
// ---------------------------------------------------------------------------
interface spi_shift_xcvr_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
);
  logic             load;
  logic [WIDTH-1:0] tx_data;
  logic             lsb_first;
  logic             sample_stb;
  logic             shift_stb;
  logic             miso;
  logic             mosi;
  logic [WIDTH-1:0] rx_data;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] bit_cnt;
`ifdef SPI_XCVR_OVERRUN_EN
  logic             rx_ack;
  logic             rx_valid;
  logic             overrun;
`endif

  modport master (
    output load, tx_data, lsb_first, sample_stb, shift_stb, miso,
`ifdef SPI_XCVR_OVERRUN_EN
    output rx_ack,
    input  rx_valid, overrun,
`endif
    input  mosi, rx_data, busy, done, bit_cnt
  );

  modport slave (
    input  load, tx_data, lsb_first, sample_stb, shift_stb, miso,
`ifdef SPI_XCVR_OVERRUN_EN
    input  rx_ack,
    output rx_valid, overrun,
`endif
    output mosi, rx_data, busy, done, bit_cnt
  );
endinterface

// File: rtl/spi_shift_xcvr.sv
// ---------------------------------------------------------------------------
// spi_shift_xcvr
// Parametrised full-duplex SPI shift engine. A parallel TX word is loaded and
// serialised on mosi while miso is deserialised into an RX word, MSB- or
// LSB-first. The SPI clock generator supplies sample/shift strobes; the
// controller FSM starts frames with load and watches busy/done.
//
// Parameters : WIDTH  frame length in bits (2..32)
//              CNT_W  bit-counter width, 2**CNT_W >= WIDTH
// Ports      : clk  system clock, rising edge
//              rst  asynchronous, active-high reset
//              bus  spi_shift_xcvr_if.slave (load, tx_data, lsb_first,
//                   sample_stb, shift_stb, miso / mosi, rx_data, busy, done,
//                   bit_cnt)
// Option     : define SPI_XCVR_OVERRUN_EN to add rx_ack / rx_valid / overrun
//              receive-buffer tracking.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | no frame; strobes ignored, load starts a frame
// S_ACTIVE | frame in progress; strobes shift, last sample ends the frame
// ---------------------------------------------------------------------------
module spi_shift_xcvr #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input logic            clk,
  input logic            rst,
  spi_shift_xcvr_if.slave bus
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] tx_sr_q;
  logic [WIDTH-1:0] tx_sr_d;
  logic [WIDTH-1:0] rx_sr_q;
  logic [WIDTH-1:0] rx_sr_d;
  logic [WIDTH-1:0] rx_data_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic             lsb_q;
  logic             busy_q;
  logic             done_q;
  logic             last_bit;
  logic             frame_end;

  // Next shift-register values; order follows the latched lsb_q, not the
  // live lsb_first input, so a mid-frame change on the bus has no effect.
  always_comb begin
    tx_sr_d = tx_sr_q;
    rx_sr_d = rx_sr_q;
    if (lsb_q) begin
      tx_sr_d = {1'b0, tx_sr_q[WIDTH-1:1]};
      rx_sr_d = {bus.miso, rx_sr_q[WIDTH-1:1]};
    end else begin
      tx_sr_d = {tx_sr_q[WIDTH-2:0], 1'b0};
      rx_sr_d = {rx_sr_q[WIDTH-2:0], bus.miso};
    end
  end

  assign last_bit  = (bit_cnt_q == LAST_CNT);
  assign frame_end = (state_q == S_ACTIVE) && bus.sample_stb && last_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      bit_cnt_q <= '0;
      lsb_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.load) begin
            tx_sr_q   <= bus.tx_data;
            rx_sr_q   <= '0;
            bit_cnt_q <= '0;
            lsb_q     <= bus.lsb_first;
            busy_q    <= 1'b1;
            state_q   <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          // load is deliberately not looked at here: a frame cannot be
          // restarted, and a load coinciding with the final sample is lost.
          if (bus.shift_stb) begin
            tx_sr_q <= tx_sr_d;
          end
          if (bus.sample_stb) begin
            rx_sr_q <= rx_sr_d;
            if (last_bit) begin
              rx_data_q <= rx_sr_d;
              done_q    <= 1'b1;
              busy_q    <= 1'b0;
              bit_cnt_q <= '0;
              state_q   <= S_IDLE;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mosi    = lsb_q ? tx_sr_q[0] : tx_sr_q[WIDTH-1];
  assign bus.rx_data = rx_data_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.bit_cnt = bit_cnt_q;

`ifdef SPI_XCVR_OVERRUN_EN
  logic rx_valid_q;
  logic overrun_q;

  // An ack arriving together with a completing frame acknowledges the old
  // word; the new word is then the unread one, so rx_valid stays set and
  // no overrun is flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else if (frame_end) begin
      rx_valid_q <= 1'b1;
      if (bus.rx_ack) begin
        overrun_q <= 1'b0;
      end else if (rx_valid_q) begin
        overrun_q <= 1'b1;
      end
    end else if (bus.rx_ack) begin
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end
  end

  assign bus.rx_valid = rx_valid_q;
  assign bus.overrun  = overrun_q;
`endif

endmodule

// File: tb/tb_spi_shift_xcvr.sv
module tb_spi_shift_xcvr;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_shift_xcvr_if #(.WIDTH(8),  .CNT_W(3)) bus8 ();
  spi_shift_xcvr_if #(.WIDTH(16), .CNT_W(4)) bus16 ();

  spi_shift_xcvr #(.WIDTH(8), .CNT_W(3)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  spi_shift_xcvr #(.WIDTH(16), .CNT_W(4)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16.slave)
  );

  int total = 0;
  int bad   = 0;
  logic ack_at_last = 1'b0;

  typedef struct {
    logic       lsb;
    logic [7:0] tx;
    logic       loop;     // 1: miso follows mosi
    logic [7:0] pat;      // miso sequence, first bit in [7]
    logic       both;     // sample and shift in the same cycle
    logic [7:0] exp_rx;
    logic [7:0] exp_seq;  // mosi sequence, first bit in [7]
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc8(input logic ld, input logic smp, input logic sft, input logic m);
    bus8.load       = ld;
    bus8.sample_stb = smp;
    bus8.shift_stb  = sft;
    bus8.miso       = m;
`ifdef SPI_XCVR_OVERRUN_EN
    bus8.rx_ack     = ack_at_last & smp;
`endif
    @(posedge clk);
    #1;
    bus8.load       = 1'b0;
    bus8.sample_stb = 1'b0;
    bus8.shift_stb  = 1'b0;
`ifdef SPI_XCVR_OVERRUN_EN
    bus8.rx_ack     = 1'b0;
`endif
  endtask

  // Runs one 8-bit frame. inj >= 0 asserts load (tx=FF, flipped order) on
  // that sample cycle; it must have no effect.
  task automatic run8(input string nm, input logic lsb, input logic [7:0] tx,
                      input logic loop, input logic [7:0] pat, input logic both,
                      input logic [7:0] exp_rx, input logic [7:0] exp_seq,
                      input int inj);
    logic m;
    logic ld;
    bus8.tx_data   = tx;
    bus8.lsb_first = lsb;
    cyc8(1'b1, 1'b0, 1'b0, 1'b0);
    chk({nm, " busy_after_load"}, 32'(bus8.busy), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s mosi[%0d]", nm, i), 32'(bus8.mosi), 32'(exp_seq[7-i]));
      chk($sformatf("%s bit_cnt[%0d]", nm, i), 32'(bus8.bit_cnt), 32'(i));
      m  = loop ? bus8.mosi : pat[7-i];
      ld = 1'b0;
      if (i == inj) begin
        bus8.tx_data   = 8'hFF;
        bus8.lsb_first = ~lsb;
        ld = 1'b1;
      end
      if (i == 7 && !ack_at_last) begin
        cyc8(ld, 1'b1, both, m);
      end else if (i == 7) begin
        cyc8(ld, 1'b1, both, m);
      end else if (both) begin
        cyc8(ld, 1'b1, 1'b1, m);
      end else begin
        cyc8(ld, 1'b1, 1'b0, m);
      end
      if (i < 7) begin
        chk($sformatf("%s done_early[%0d]", nm, i), 32'(bus8.done), 32'd0);
        chk($sformatf("%s busy_mid[%0d]", nm, i), 32'(bus8.busy), 32'd1);
        if (!both) cyc8(1'b0, 1'b0, 1'b1, 1'b0);
      end
    end
    chk({nm, " done"},    32'(bus8.done),    32'd1);
    chk({nm, " busy_end"}, 32'(bus8.busy),   32'd0);
    chk({nm, " rx_data"}, 32'(bus8.rx_data), 32'(exp_rx));
    chk({nm, " cnt_end"}, 32'(bus8.bit_cnt), 32'd0);
    cyc8(1'b0, 1'b0, 1'b0, 1'b0);
    chk({nm, " done_pulse"}, 32'(bus8.done), 32'd0);
    chk({nm, " rx_hold"}, 32'(bus8.rx_data), 32'(exp_rx));
    chk({nm, " idle_busy"}, 32'(bus8.busy), 32'd0);
  endtask

  initial begin
    logic [15:0] seq16;
    int          done_seen;

    vecs[0] = '{lsb:1'b0, tx:8'hA5, loop:1'b1, pat:8'h00, both:1'b0, exp_rx:8'hA5, exp_seq:8'hA5};
    vecs[1] = '{lsb:1'b1, tx:8'h01, loop:1'b0, pat:8'hC0, both:1'b0, exp_rx:8'h03, exp_seq:8'h80};
    vecs[2] = '{lsb:1'b0, tx:8'h3C, loop:1'b0, pat:8'h96, both:1'b1, exp_rx:8'h96, exp_seq:8'h3C};
    vecs[3] = '{lsb:1'b1, tx:8'hC3, loop:1'b1, pat:8'h00, both:1'b0, exp_rx:8'hC3, exp_seq:8'hC3};
    vecs[4] = '{lsb:1'b1, tx:8'h5A, loop:1'b0, pat:8'hF0, both:1'b1, exp_rx:8'h0F, exp_seq:8'h5A};
    vecs[5] = '{lsb:1'b0, tx:8'h00, loop:1'b0, pat:8'hFF, both:1'b0, exp_rx:8'hFF, exp_seq:8'h00};

    rst = 1'b1;
    bus8.load = 1'b0; bus8.tx_data = '0; bus8.lsb_first = 1'b0;
    bus8.sample_stb = 1'b0; bus8.shift_stb = 1'b0; bus8.miso = 1'b0;
    bus16.load = 1'b0; bus16.tx_data = '0; bus16.lsb_first = 1'b0;
    bus16.sample_stb = 1'b0; bus16.shift_stb = 1'b0; bus16.miso = 1'b0;
`ifdef SPI_XCVR_OVERRUN_EN
    bus8.rx_ack = 1'b0;
    bus16.rx_ack = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst mosi",    32'(bus8.mosi),    32'd0);
    chk("rst busy",    32'(bus8.busy),    32'd0);
    chk("rst done",    32'(bus8.done),    32'd0);
    chk("rst rx_data", 32'(bus8.rx_data), 32'd0);
    chk("rst bit_cnt", 32'(bus8.bit_cnt), 32'd0);
    rst = 1'b0;
    cyc8(1'b0, 1'b0, 1'b0, 1'b0);

    // Strobes while idle must do nothing.
    cyc8(1'b0, 1'b1, 1'b1, 1'b1);
    cyc8(1'b0, 1'b1, 1'b0, 1'b1);
    chk("idle_stb bit_cnt", 32'(bus8.bit_cnt), 32'd0);
    chk("idle_stb busy",    32'(bus8.busy),    32'd0);
    chk("idle_stb done",    32'(bus8.done),    32'd0);
    chk("idle_stb rx_data", 32'(bus8.rx_data), 32'd0);

    for (int v = 0; v < 6; v++) begin
      run8($sformatf("vec%0d", v), vecs[v].lsb, vecs[v].tx, vecs[v].loop,
           vecs[v].pat, vecs[v].both, vecs[v].exp_rx, vecs[v].exp_seq, -1);
    end

    // load during the frame and on the completing sample are both ignored.
    run8("midload", 1'b0, 8'h96, 1'b1, 8'h00, 1'b0, 8'h96, 8'h96, 3);
    run8("lastload", 1'b1, 8'h6E, 1'b1, 8'h00, 1'b0, 8'h6E, 8'h76, 7);

    // Asynchronous reset after 4 samples aborts without a done pulse.
    bus8.tx_data = 8'h5A; bus8.lsb_first = 1'b0;
    cyc8(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc8(1'b0, 1'b1, 1'b0, bus8.mosi);
      cyc8(1'b0, 1'b0, 1'b1, 1'b0);
    end
    chk("abort pre_cnt", 32'(bus8.bit_cnt), 32'd4);
    #2 rst = 1'b1;
    #1;
    chk("abort busy",    32'(bus8.busy),    32'd0);
    chk("abort rx_data", 32'(bus8.rx_data), 32'd0);
    chk("abort bit_cnt", 32'(bus8.bit_cnt), 32'd0);
    chk("abort mosi",    32'(bus8.mosi),    32'd0);
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus8.done) done_seen++;
    end
    rst = 1'b0;
    cyc8(1'b0, 1'b0, 1'b0, 1'b0);
    if (bus8.done) done_seen++;
    chk("abort no_done", 32'(done_seen), 32'd0);
    run8("postabort", 1'b0, 8'hA5, 1'b1, 8'h00, 1'b0, 8'hA5, 8'hA5, -1);

    // 16-bit instance: MSB-first 8001 with miso held low.
    bus16.tx_data = 16'h8001; bus16.lsb_first = 1'b0; bus16.miso = 1'b0;
    bus16.load = 1'b1;
    @(posedge clk); #1;
    bus16.load = 1'b0;
    seq16 = '0;
    for (int i = 0; i < 16; i++) begin
      seq16[15-i] = bus16.mosi;
      if (i == 15) chk("w16 cnt_last", 32'(bus16.bit_cnt), 32'd15);
      bus16.sample_stb = 1'b1;
      @(posedge clk); #1;
      bus16.sample_stb = 1'b0;
      if (i < 15) begin
        if (bus16.done !== 1'b0 || bus16.busy !== 1'b1)
          chk($sformatf("w16 early_end[%0d]", i), {bus16.done, bus16.busy}, 32'b01);
        bus16.shift_stb = 1'b1;
        @(posedge clk); #1;
        bus16.shift_stb = 1'b0;
      end
    end
    chk("w16 done",    32'(bus16.done),    32'd1);
    chk("w16 busy",    32'(bus16.busy),    32'd0);
    chk("w16 rx_data", 32'(bus16.rx_data), 32'h0000);
    chk("w16 mosi_seq", 32'(seq16),        32'h8001);

`ifdef SPI_XCVR_OVERRUN_EN
    bus8.rx_ack = 1'b1;
    @(posedge clk); #1;
    bus8.rx_ack = 1'b0;
    chk("ovr clr rx_valid", 32'(bus8.rx_valid), 32'd0);
    chk("ovr clr overrun",  32'(bus8.overrun),  32'd0);
    run8("ovr f1", 1'b0, 8'h12, 1'b1, 8'h00, 1'b0, 8'h12, 8'h12, -1);
    chk("ovr f1 rx_valid", 32'(bus8.rx_valid), 32'd1);
    chk("ovr f1 overrun",  32'(bus8.overrun),  32'd0);
    run8("ovr f2", 1'b0, 8'h34, 1'b1, 8'h00, 1'b0, 8'h34, 8'h34, -1);
    chk("ovr f2 overrun",  32'(bus8.overrun),  32'd1);
    chk("ovr f2 rx_valid", 32'(bus8.rx_valid), 32'd1);
    bus8.rx_ack = 1'b1;
    @(posedge clk); #1;
    bus8.rx_ack = 1'b0;
    chk("ovr ack rx_valid", 32'(bus8.rx_valid), 32'd0);
    chk("ovr ack overrun",  32'(bus8.overrun),  32'd0);
    run8("ovr f3", 1'b1, 8'h01, 1'b1, 8'h00, 1'b0, 8'h01, 8'h80, -1);
    ack_at_last = 1'b1;
    run8("ovr f4", 1'b0, 8'h55, 1'b1, 8'h00, 1'b0, 8'h55, 8'h55, -1);
    ack_at_last = 1'b0;
    chk("ovr same rx_valid", 32'(bus8.rx_valid), 32'd1);
    chk("ovr same overrun",  32'(bus8.overrun),  32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
